// File: rtl/sump_pkg.sv
// Shared SUMP definitions: opcodes, the long-format opcode bit and the
// command serializer state encoding.
package sump_pkg;

   localparam logic [7:0] SUMP_RESET     = 8'h00;
   localparam logic [7:0] SUMP_RUN       = 8'h01;
   localparam logic [7:0] SUMP_ID        = 8'h02;
   localparam logic [7:0] SUMP_XON       = 8'h11;
   localparam logic [7:0] SUMP_XOFF      = 8'h13;
   localparam logic [7:0] SUMP_SET_DIV   = 8'h80;
   localparam logic [7:0] SUMP_SET_CNT   = 8'h81;
   localparam logic [7:0] SUMP_SET_FLAGS = 8'h82;

   // Opcodes with this bit set carry a DW-bit argument after the opcode byte.
   localparam int SUMP_LBIT = 7;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PRE  = 2'd1,
      CODE = 2'd2,
      DATA = 2'd3
   } sump_tx_state_t;

endpackage

// File: rtl/sump_cmd_tx.sv
// SUMP command serializer: one opcode/argument command in, SUMP byte stream out.
// Optional soft-reset preamble after reset release: define SUMP_CMD_TX_PREAMBLE_EN.
module sump_cmd_tx
   import sump_pkg::*;
#(
   parameter int DW    = 32,
   parameter int LBIT  = SUMP_LBIT,
   parameter int PRE_N = 5
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cmd_tvalid,
   output logic          cmd_tready,
   input  logic [7:0]    cmd_code,
   input  logic [DW-1:0] cmd_data,
   output logic          str_txd_tvalid,
   output logic [7:0]    str_txd_tdata,
   input  logic          str_txd_tready,
   output logic          busy
);

   localparam int NB = DW / 8;
   localparam int CW = (NB > 1) ? $clog2(NB) : 1;
`ifdef SUMP_CMD_TX_PREAMBLE_EN
   localparam int PW = (PRE_N > 1) ? $clog2(PRE_N) : 1;
   localparam int KW = (CW > PW) ? CW : PW;
   localparam logic [KW-1:0] PRE_LAST = KW'(PRE_N - 1);
`else
   localparam int KW = CW;
`endif
   localparam logic [KW-1:0] DATA_LAST = KW'(NB - 1);

   generate
      if ((DW % 8) != 0 || DW < 8) begin : g_bad_dw
         $error("sump_cmd_tx: DW must be a non-zero multiple of 8");
      end
      if (LBIT < 0 || LBIT > 7) begin : g_bad_lbit
         $error("sump_cmd_tx: LBIT must select a bit of the opcode");
      end
      if (PRE_N < 1) begin : g_bad_pre
         $error("sump_cmd_tx: PRE_N must be at least 1");
      end
   endgenerate

   sump_tx_state_t state;
   logic [KW-1:0]  cnt;
   logic [7:0]     code_q;
   logic [DW-1:0]  data_q;
   logic           armed;
   logic           last_byte;
   logic           accept;

   // armed holds cmd_tready low during reset and for the first cycle after release.
   always_comb begin
      last_byte = ((state == CODE) && !code_q[LBIT]) ||
                  ((state == DATA) && (cnt == DATA_LAST));
   end

   assign cmd_tready     = armed && ((state == IDLE) || (last_byte && str_txd_tready));
   assign accept         = cmd_tvalid && cmd_tready;
   assign str_txd_tvalid = (state != IDLE);
   assign busy           = str_txd_tvalid;

   always_comb begin
      str_txd_tdata = 8'h00;
      case (state)
         CODE:    str_txd_tdata = code_q;
         DATA:    str_txd_tdata = data_q[{cnt, 3'b000} +: 8];
         default: str_txd_tdata = 8'h00;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         cnt    <= '0;
         code_q <= 8'h00;
         data_q <= '0;
         armed  <= 1'b0;
      end else begin
         armed <= 1'b1;
         case (state)
            IDLE: begin
`ifdef SUMP_CMD_TX_PREAMBLE_EN
               if (!armed) begin
                  state <= PRE;
                  cnt   <= '0;
               end else
`endif
               if (accept) begin
                  code_q <= cmd_code;
                  data_q <= cmd_data;
                  state  <= CODE;
               end
            end
`ifdef SUMP_CMD_TX_PREAMBLE_EN
            PRE: begin
               if (str_txd_tready) begin
                  if (cnt == PRE_LAST) begin
                     state <= IDLE;
                  end else begin
                     cnt <= cnt + KW'(1);
                  end
               end
            end
`endif
            CODE: begin
               if (str_txd_tready) begin
                  if (code_q[LBIT]) begin
                     state <= DATA;
                     cnt   <= '0;
                  end else if (accept) begin
                     code_q <= cmd_code;
                     data_q <= cmd_data;
                     state  <= CODE;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            // The last data byte may overlap with accepting the next command.
            DATA: begin
               if (str_txd_tready) begin
                  if (cnt != DATA_LAST) begin
                     cnt <= cnt + KW'(1);
                  end else if (accept) begin
                     code_q <= cmd_code;
                     data_q <= cmd_data;
                     state  <= CODE;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sump_cmd_tx.sv
// Scoreboard bench for sump_cmd_tx: expected bytes are queued when a command is
// accepted and compared against the bytes handshaken on the TXD stream.
`timescale 1ns/1ps
module tb_sump_cmd_tx;
   import sump_pkg::*;

   localparam int DW    = 32;
   localparam int NB    = DW / 8;
   localparam int PRE_N = 5;
`ifdef SUMP_CMD_TX_PREAMBLE_EN
   localparam int READY_IDX = PRE_N + 1;
`else
   localparam int READY_IDX = 1;
`endif

   typedef struct {
      logic [7:0] b;
      int         cyc;
   } obs_t;

   logic          clk;
   logic          rst;
   logic          cmd_tvalid;
   logic          cmd_tready;
   logic [7:0]    cmd_code;
   logic [DW-1:0] cmd_data;
   logic          str_txd_tvalid;
   logic [7:0]    str_txd_tdata;
   logic          str_txd_tready;
   logic          busy;

   logic       ready_force;
   logic       rnd_bit;
   bit         rand_ready;
   obs_t       obs_q[$];
   logic [7:0] exp_q[$];
   int         compared;
   int         mismatched;
   int         cyc;
   int         valid_cycles;
   int         busy_cycles;
   int         acc_cyc;

   sump_cmd_tx #(.DW(DW), .LBIT(SUMP_LBIT), .PRE_N(PRE_N)) dut (
      .clk            (clk),
      .rst            (rst),
      .cmd_tvalid     (cmd_tvalid),
      .cmd_tready     (cmd_tready),
      .cmd_code       (cmd_code),
      .cmd_data       (cmd_data),
      .str_txd_tvalid (str_txd_tvalid),
      .str_txd_tdata  (str_txd_tdata),
      .str_txd_tready (str_txd_tready),
      .busy           (busy)
   );

   assign str_txd_tready = rand_ready ? rnd_bit : ready_force;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) begin
      cyc     <= cyc + 1;
      rnd_bit <= ($urandom_range(0, 3) != 0);
   end

   // Monitor: records every handshaken byte with the cycle it completed in.
   always @(negedge clk) begin
      if (!rst) begin
         if (str_txd_tvalid) valid_cycles++;
         if (busy) busy_cycles++;
         if (str_txd_tvalid && str_txd_tready)
            obs_q.push_back('{b: str_txd_tdata, cyc: cyc});
      end
   end

   initial begin
      #600000;
      $display("[TB] FAIL watchdog: simulation still running, required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic push_preamble();
`ifdef SUMP_CMD_TX_PREAMBLE_EN
      for (int i = 0; i < PRE_N; i++) exp_q.push_back(8'h00);
`endif
   endtask

   task automatic send_cmd(input logic [7:0] code, input logic [DW-1:0] data);
      int n;
      bit ok;
      cmd_code   = code;
      cmd_data   = data;
      cmd_tvalid = 1'b1;
      n  = 0;
      ok = 1'b0;
      while (!ok && n < 200) begin
         @(negedge clk);
         ok = cmd_tready;
         if (ok) acc_cyc = cyc;
         @(posedge clk);
         #1;
         n++;
      end
      cmd_tvalid = 1'b0;
      cmd_code   = 8'hEE;
      cmd_data   = $urandom;
      compared++;
      if (!ok) begin
         mismatched++;
         $display("[TB] FAIL accept_%02h: not accepted after %0d cycles, required acceptance", code, n);
      end else begin
         exp_q.push_back(code);
         if (code[SUMP_LBIT])
            for (int k = 0; k < NB; k++) exp_q.push_back(data[8*k +: 8]);
      end
   endtask

   task automatic wait_drain(output bit timeout);
      timeout = 1'b1;
      for (int n = 0; n < 400; n++) begin
         @(negedge clk);
         if (obs_q.size() >= exp_q.size() && !str_txd_tvalid) begin
            timeout = 1'b0;
            break;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      bit to;
      int n;
      logic [7:0] e;
      obs_t o;
      obs_q.delete();
      exp_q.delete();
      ready_force = 1'b1;
      cmd_tvalid  = 1'b1;
      cmd_code    = SUMP_ID;
      cmd_data    = '0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      @(negedge clk);
      compared += 4;
      if (str_txd_tvalid !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_tvalid: got %b, required 0", str_txd_tvalid); end
      if (str_txd_tdata !== 8'h00) begin mismatched++; $display("[TB] FAIL rst_tdata: got %02h, required 00", str_txd_tdata); end
      if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_busy: got %b, required 0", busy); end
      if (cmd_tready !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_cmd_tready: got %b, required 0", cmd_tready); end
      @(posedge clk);
      #1;
      rst = 1'b0;
      push_preamble();
      n = 0;
      while (n < 50) begin
         @(negedge clk);
         if (cmd_tready === 1'b1) break;
         n++;
      end
      compared++;
      if (n !== READY_IDX) begin
         mismatched++;
         $display("[TB] FAIL ready_after_release: first ready at cycle %0d, required %0d", n, READY_IDX);
      end
      exp_q.push_back(SUMP_ID);
      @(posedge clk);
      #1;
      cmd_tvalid = 1'b0;
      wait_drain(to);
      compared++;
      if (to) begin mismatched++; $display("[TB] FAIL reset_drain: timed out, required drain"); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         compared++;
         if (obs_q.size() == 0) begin
            mismatched++;
            $display("[TB] FAIL reset_byte: got nothing, required %02h", e);
         end else begin
            o = obs_q.pop_front();
            if (o.b !== e) begin mismatched++; $display("[TB] FAIL reset_byte: got %02h, required %02h", o.b, e); end
         end
      end
      compared++;
      if (obs_q.size() != 0) begin mismatched++; $display("[TB] FAIL reset_extra: got %0d extra bytes, required 0", obs_q.size()); end
   endtask

   task automatic test_short();
      bit to;
      logic [7:0] e;
      obs_t o;
      obs_q.delete();
      exp_q.delete();
      ready_force  = 1'b1;
      valid_cycles = 0;
      send_cmd(SUMP_RUN, 32'hDEADBEEF);
      wait_drain(to);
      compared += 3;
      if (to) begin mismatched++; $display("[TB] FAIL short_drain: timed out, required drain"); end
      if (valid_cycles !== 1) begin mismatched++; $display("[TB] FAIL short_valid_cycles: got %0d, required 1", valid_cycles); end
      if (obs_q.size() == 0 || obs_q[0].cyc !== acc_cyc + 1) begin
         mismatched++;
         $display("[TB] FAIL short_latency: byte at cycle %0d, required %0d", (obs_q.size() == 0) ? -1 : obs_q[0].cyc, acc_cyc + 1);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         compared++;
         if (obs_q.size() == 0) begin
            mismatched++;
            $display("[TB] FAIL short_byte: got nothing, required %02h", e);
         end else begin
            o = obs_q.pop_front();
            if (o.b !== e) begin mismatched++; $display("[TB] FAIL short_byte: got %02h, required %02h", o.b, e); end
         end
      end
      compared++;
      if (obs_q.size() != 0) begin mismatched++; $display("[TB] FAIL short_extra: got %0d extra bytes, required 0", obs_q.size()); end
   endtask

   task automatic test_long();
      bit to;
      bit gap;
      logic [7:0] e;
      obs_t o;
      obs_q.delete();
      exp_q.delete();
      ready_force  = 1'b1;
      valid_cycles = 0;
      busy_cycles  = 0;
      send_cmd(SUMP_SET_DIV, 32'h04030201);
      wait_drain(to);
      gap = 1'b0;
      for (int i = 1; i < obs_q.size(); i++)
         if (obs_q[i].cyc != obs_q[i-1].cyc + 1) gap = 1'b1;
      compared += 5;
      if (to) begin mismatched++; $display("[TB] FAIL long_drain: timed out, required drain"); end
      if (busy_cycles !== 5) begin mismatched++; $display("[TB] FAIL long_busy_cycles: got %0d, required 5", busy_cycles); end
      if (valid_cycles !== 5) begin mismatched++; $display("[TB] FAIL long_valid_cycles: got %0d, required 5", valid_cycles); end
      if (gap) begin mismatched++; $display("[TB] FAIL long_consecutive: got gaps, required none"); end
      if (obs_q.size() == 0 || obs_q[0].cyc !== acc_cyc + 1) begin
         mismatched++;
         $display("[TB] FAIL long_latency: first byte late, required cycle %0d", acc_cyc + 1);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         compared++;
         if (obs_q.size() == 0) begin
            mismatched++;
            $display("[TB] FAIL long_byte: got nothing, required %02h", e);
         end else begin
            o = obs_q.pop_front();
            if (o.b !== e) begin mismatched++; $display("[TB] FAIL long_byte: got %02h, required %02h", o.b, e); end
         end
      end
      compared++;
      if (obs_q.size() != 0) begin mismatched++; $display("[TB] FAIL long_extra: got %0d extra bytes, required 0", obs_q.size()); end
   endtask

   task automatic test_backpressure();
      bit to;
      logic [7:0] e;
      obs_t o;
      obs_q.delete();
      exp_q.delete();
      ready_force  = 1'b1;
      valid_cycles = 0;
      send_cmd(SUMP_SET_DIV, 32'h04030201);
      @(posedge clk);
      @(posedge clk);
      #1;
      ready_force = 1'b0;
      cmd_tvalid  = 1'b1;
      cmd_code    = SUMP_XON;
      cmd_data    = 32'hA5A5A5A5;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         compared += 3;
         if (str_txd_tdata !== 8'h02) begin mismatched++; $display("[TB] FAIL bp_hold_tdata: got %02h, required 02", str_txd_tdata); end
         if (str_txd_tvalid !== 1'b1) begin mismatched++; $display("[TB] FAIL bp_hold_tvalid: got %b, required 1", str_txd_tvalid); end
         if (cmd_tready !== 1'b0) begin mismatched++; $display("[TB] FAIL bp_cmd_tready: got %b, required 0", cmd_tready); end
      end
      @(posedge clk);
      #1;
      cmd_tvalid  = 1'b0;
      ready_force = 1'b1;
      wait_drain(to);
      compared += 2;
      if (to) begin mismatched++; $display("[TB] FAIL bp_drain: timed out, required drain"); end
      if (valid_cycles !== 8) begin mismatched++; $display("[TB] FAIL bp_valid_cycles: got %0d, required 8", valid_cycles); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         compared++;
         if (obs_q.size() == 0) begin
            mismatched++;
            $display("[TB] FAIL bp_byte: got nothing, required %02h", e);
         end else begin
            o = obs_q.pop_front();
            if (o.b !== e) begin mismatched++; $display("[TB] FAIL bp_byte: got %02h, required %02h", o.b, e); end
         end
      end
      compared++;
      if (obs_q.size() != 0) begin mismatched++; $display("[TB] FAIL bp_extra: got %0d extra bytes, required 0", obs_q.size()); end
   endtask

   task automatic test_back_to_back();
      bit to;
      bit gap;
      logic [7:0] e;
      obs_t o;
      obs_q.delete();
      exp_q.delete();
      ready_force = 1'b1;
      send_cmd(SUMP_SET_FLAGS, 32'h00000F00);
      send_cmd(SUMP_RUN, 32'h12345678);
      wait_drain(to);
      gap = 1'b0;
      for (int i = 1; i < obs_q.size(); i++)
         if (obs_q[i].cyc != obs_q[i-1].cyc + 1) gap = 1'b1;
      compared += 3;
      if (to) begin mismatched++; $display("[TB] FAIL b2b_drain: timed out, required drain"); end
      if (obs_q.size() !== 6) begin mismatched++; $display("[TB] FAIL b2b_count: got %0d bytes, required 6", obs_q.size()); end
      if (gap) begin mismatched++; $display("[TB] FAIL b2b_no_gap: got idle cycles, required none"); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         compared++;
         if (obs_q.size() == 0) begin
            mismatched++;
            $display("[TB] FAIL b2b_byte: got nothing, required %02h", e);
         end else begin
            o = obs_q.pop_front();
            if (o.b !== e) begin mismatched++; $display("[TB] FAIL b2b_byte: got %02h, required %02h", o.b, e); end
         end
      end
      compared++;
      if (obs_q.size() != 0) begin mismatched++; $display("[TB] FAIL b2b_extra: got %0d extra bytes, required 0", obs_q.size()); end
   endtask

   task automatic test_reset_mid();
      bit to;
      logic [7:0] e;
      obs_t o;
      obs_q.delete();
      exp_q.delete();
      ready_force = 1'b1;
      send_cmd(SUMP_SET_DIV, 32'h04030201);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      compared += 4;
      if (str_txd_tvalid !== 1'b0) begin mismatched++; $display("[TB] FAIL mid_rst_tvalid: got %b, required 0", str_txd_tvalid); end
      if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL mid_rst_busy: got %b, required 0", busy); end
      if (str_txd_tdata !== 8'h00) begin mismatched++; $display("[TB] FAIL mid_rst_tdata: got %02h, required 00", str_txd_tdata); end
      if (obs_q.size() !== 2) begin mismatched++; $display("[TB] FAIL mid_partial_count: got %0d bytes, required 2", obs_q.size()); end
      for (int i = 0; i < 2; i++) begin
         e = exp_q.pop_front();
         compared++;
         if (obs_q.size() == 0) begin
            mismatched++;
            $display("[TB] FAIL mid_partial_byte: got nothing, required %02h", e);
         end else begin
            o = obs_q.pop_front();
            if (o.b !== e) begin mismatched++; $display("[TB] FAIL mid_partial_byte: got %02h, required %02h", o.b, e); end
         end
      end
      exp_q.delete();
      obs_q.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      push_preamble();
      send_cmd(SUMP_ID, 32'h0);
      wait_drain(to);
      compared++;
      if (to) begin mismatched++; $display("[TB] FAIL mid_drain: timed out, required drain"); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         compared++;
         if (obs_q.size() == 0) begin
            mismatched++;
            $display("[TB] FAIL mid_after_byte: got nothing, required %02h", e);
         end else begin
            o = obs_q.pop_front();
            if (o.b !== e) begin mismatched++; $display("[TB] FAIL mid_after_byte: got %02h, required %02h", o.b, e); end
         end
      end
      compared++;
      if (obs_q.size() != 0) begin mismatched++; $display("[TB] FAIL mid_extra: got %0d extra bytes, required 0", obs_q.size()); end
   endtask

   task automatic test_random();
      bit to;
      logic [7:0] e;
      obs_t o;
      logic [7:0] ops [8];
      ops = '{SUMP_RESET, SUMP_RUN, SUMP_ID, SUMP_XON, SUMP_XOFF, SUMP_SET_DIV, SUMP_SET_CNT, SUMP_SET_FLAGS};
      obs_q.delete();
      exp_q.delete();
      rand_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         send_cmd(ops[$urandom_range(0, 7)], $urandom);
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #1;
      end
      wait_drain(to);
      rand_ready  = 1'b0;
      ready_force = 1'b1;
      compared++;
      if (to) begin mismatched++; $display("[TB] FAIL rand_drain: timed out, required drain"); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         compared++;
         if (obs_q.size() == 0) begin
            mismatched++;
            $display("[TB] FAIL rand_byte: got nothing, required %02h", e);
         end else begin
            o = obs_q.pop_front();
            if (o.b !== e) begin mismatched++; $display("[TB] FAIL rand_byte: got %02h, required %02h", o.b, e); end
         end
      end
      compared++;
      if (obs_q.size() != 0) begin mismatched++; $display("[TB] FAIL rand_extra: got %0d extra bytes, required 0", obs_q.size()); end
   endtask

   initial begin
      compared     = 0;
      mismatched   = 0;
      cyc          = 0;
      valid_cycles = 0;
      busy_cycles  = 0;
      acc_cyc      = 0;
      rand_ready   = 1'b0;
      ready_force  = 1'b1;
      rst          = 1'b1;
      cmd_tvalid   = 1'b0;
      cmd_code     = 8'h00;
      cmd_data     = '0;
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      test_short();
      test_long();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/sump_cmd_tx.md
Name: sump_cmd_tx

Overview:
- Host-side SUMP command serializer: the transmit end of the protocol that the ctrl command parser receives.
- Accepts one decoded command (opcode + 32-bit argument) on a valid/ready port and emits it as the SUMP byte sequence on an 8-bit TXD stream that feeds a uart transmitter.
- Used by the on-chip self-test/loopback sequencer and by benches that drive the analyzer core through its real uart path.

Parameters:
- DW, 32, command argument width in bits; must be a multiple of 8; NB = DW/8 data bytes per long command.
- LBIT, 7, opcode bit selecting long format (1 = long, opcode + NB data bytes; 0 = short, opcode only).
- PRE_N, 5, number of 0x00 reset bytes in the preamble (used only with the optional feature).

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- cmd_tvalid  input  1  command valid.
- cmd_tready  output  1  command accepted when cmd_tvalid & cmd_tready.
- cmd_code  input  8  SUMP opcode.
- cmd_data  input  DW  argument, sent LSB byte first.
- str_txd_tvalid  output  1  byte valid toward the uart.
- str_txd_tdata  output  8  byte.
- str_txd_tready  input  1  uart accepts the byte.
- busy  output  1  high while any byte of a command or the preamble is pending.

Behaviour:
- Reset is asynchronous, active-high, with clock clk. While in reset:
  - state = IDLE;
  - str_txd_tvalid = 0, str_txd_tdata = 0x00;
  - busy = 0;
  - cmd_tready = 0 during rst and in the first cycle after release, then 1.
- States:
  - IDLE: no byte pending.
  - CODE: opcode byte presented.
  - DATA: data byte k presented, k = 0..NB-1.
  - PRE: preamble, feature only.
- Accept rule: cmd_tready = (state == IDLE) | (last byte of current command is on the bus & str_txd_tready). This gives back-to-back commands with no gap cycle. cmd_tready is the only combinational path from str_txd_tready.
- On accept: latch code and data. The next cycle, str_txd_tvalid = 1 and tdata = code, state = CODE (latency 1).
- CODE & tready:
  - long (code[LBIT] = 1) -> DATA with k = 0, tdata = data[7:0];
  - short -> IDLE, or CODE again if a new command is accepted in the same cycle.
- DATA k & tready:
  - k < NB-1 -> k+1, tdata = data[8k+15:8k+8];
  - k = NB-1 -> IDLE, or CODE if a new command is accepted.
- Stream rules:
  - while tvalid & !tready, tdata and the latched command hold stable;
  - tvalid never drops before its handshake;
  - cmd_code/cmd_data are ignored when not accepted.
- busy = str_txd_tvalid.
- The byte counter is ceil(log2(NB)) bits wide. It is cleared on entry to DATA and never wraps past NB-1.
- Reset mid-command: the command is discarded, no partial bytes resume, and the block returns to IDLE.
- cmd_tvalid asserted together with reset release: the command is not accepted until cmd_tready is high.

Optional Feature:
- Macro SUMP_CMD_TX_PREAMBLE_EN.
- Defined:
  - after reset release, the state is PRE and PRE_N bytes of 0x00 are emitted before any command (the SUMP soft-reset sequence);
  - cmd_tready = 0 and busy = 1 throughout;
  - the counter is reused for PRE; after the last handshake -> IDLE.
- Undefined: no PRE state or logic; behaviour is exactly as above.

Decomposition:
- Shared package sump_pkg:
  - opcode constants: SUMP_RESET 0x00, SUMP_RUN 0x01, SUMP_ID 0x02, SUMP_XON 0x11, SUMP_XOFF 0x13, SUMP_SET_DIV 0x80, SUMP_SET_CNT 0x81, SUMP_SET_FLAGS 0x82;
  - LBIT default;
  - state enum typedef sump_tx_state_t {IDLE, PRE, CODE, DATA}.
- Single flat module; no sub-module is needed. The byte mux is an indexed part-select of the latched argument.

Test Plan:
- Short command, tready held 1: code 0x01 -> exactly one byte 0x01, tvalid for 1 cycle, appearing the cycle after accept.
- Long command, tready 1: code 0x80, data 0x04030201 -> bytes 0x80, 0x01, 0x02, 0x03, 0x04 on consecutive cycles, busy 5 cycles.
- Backpressure: tready low for 3 cycles on byte 0x02 -> tdata holds 0x02, tvalid stays 1, cmd_tready stays 0, and the sequence completes unchanged.
- Back-to-back: 0x82/0x00000F00 followed immediately by 0x01 -> 0x82 00 0F 00 00 01 with no idle cycle between commands.
- Reset after byte 0x01 of a long command -> tvalid = 0 within the reset, no remaining bytes afterwards, and the next command 0x02 yields the single byte 0x02.
- With SUMP_CMD_TX_PREAMBLE_EN, PRE_N = 5: reset release -> five 0x00 bytes, cmd_tready = 0 until the fifth is accepted, then a queued 0x02 is sent.
